uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART serial transmitter. Accepts a parallel byte on a one-cycle start request and shifts it out LSB-first as start bit, data bits, optional parity bit and stop bit(s). Bit timing is paced by an external oversampling tick, s_tick, at 16x the baud rate, produced by the shared baud generator. Sits between the host/FIFO side and the tx pin.

Parameters:
- DBIT, 8: number of data bits per frame (legal range 5..8).
- SB_TICK, 16: s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- tx_start  in  1  request to send din; sampled only in IDLE.
- s_tick  in  1  one-clk-wide 16x-baud enable pulse.
- din  in  DBIT  byte to transmit; captured when the request is accepted.
- tx_done_tick  out  1  one-clk pulse at the end of the stop period.
- tx  out  1  serial line, idle high; registered output.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; tick counter s=0; bit counter n=0; shift reg=0; tx=1; tx_done_tick=0. On release, the block is in IDLE.
- States:
  - IDLE: tx=1. If tx_start=1 at a clk edge, latch din into the shift register, set s=0 and go to START. s_tick is ignored in IDLE.
  - START: tx=0. On each s_tick, s++. On the s_tick with s=15: s=0, n=0, go to DATA.
  - DATA: tx=shift[0]. On the s_tick with s=15: s=0, shift right by 1. If n=DBIT-1, go to PARITY (PARITY!=0) or STOP; otherwise n++.
  - PARITY: tx = XOR of latched data (even) or its inverse (odd). Lasts 16 s_ticks, then go to STOP.
  - STOP: tx=1. On the s_tick with s=SB_TICK-1: s=0, go to IDLE, and assert tx_done_tick.
- Timing:
  - tx is registered from next-state logic, so the tx value changes on the same edge the state changes.
  - tx_done_tick is registered: high for exactly the one clk cycle after the final stop tick edge, i.e. the first cycle back in IDLE.
- Frame length (s_tick continuously high, defaults): 16 + 8×16 + 16 = 160 clk cycles.
- Back-to-back frames: if tx_start is still high in the tx_done_tick cycle, the next frame is accepted on that edge. The line holds 1 for exactly that one cycle between frames.
- Ignored inputs:
  - tx_start outside IDLE is ignored; no queuing.
  - din changes after acceptance do not affect the frame in flight.
- s_tick low: all counters and tx hold indefinitely (pause).
- Reset mid-frame: frame is aborted immediately; tx=1; no tx_done_tick is generated.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - OSR=16 constant.
- No sub-module inside uart_tx. The s_tick source is the separate uart_baud_gen block and is not instantiated here.

Test Plan:
- Reset: hold reset=0 with tx_start=1 -> tx=1, tx_done_tick=0 throughout. Release reset -> IDLE.
- Single frame, defaults: din=8'hBE, s_tick=1 constantly, pulse tx_start -> tx sequence in 16-cycle bit slots is 0 | 0,1,1,1,1,1,0,1 | 1. tx_done_tick high for 1 cycle at cycle 161 after acceptance.
- Continuous tx_start=1 with din=8'hBE -> repeated 160-cycle frames separated by exactly one idle-high cycle, one tx_done_tick per frame.
- Sparse s_tick (1 in every 4 clks), din=8'h55 -> each bit lasts 64 clks, pattern 0 | 1,0,1,0,1,0,1,0 | 1.
- Parity: PARITY=1, din=8'h07 -> parity bit 1. PARITY=2, same din -> parity bit 0. Frame length becomes 176 ticks.
- Reset asserted mid-DATA -> tx goes to 1 asynchronously, no tx_done_tick. The next tx_start after release produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART transmit path.
//   state_t     : transmitter frame phase
//   PAR_*       : parity mode selectors for the PARITY parameter
//   OSR         : s_tick pulses per bit slot (16x oversampling)
//   parity_line : line level of the parity bit for a given data XOR
package uart_pkg;

  localparam int OSR = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // data_xor is the XOR of all data bits; even parity sends it as-is so the
  // total count of ones (data + parity) is even, odd parity sends its inverse.
  function automatic logic parity_line(input logic data_xor, input int mode);
    logic bit_val;
    case (mode)
      PAR_EVEN: bit_val = data_xor;
      PAR_ODD:  bit_val = ~data_xor;
      default:  bit_val = 1'b1;
    endcase
    return bit_val;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx
//   UART serial transmitter. A one-cycle tx_start in IDLE captures din and
//   sends it LSB-first as start bit, DBIT data bits, optional parity bit and
//   stop period, each bit slot paced by OSR pulses of the 16x s_tick enable.
//
//   Ports
//     clk           system clock, rising edge
//     reset         asynchronous reset, active low
//     tx_start      send request, only looked at in IDLE
//     s_tick        one-clk 16x-baud enable; low pauses the frame
//     din           data word, captured on acceptance
//     tx_done_tick  one-clk pulse, first cycle back in IDLE after a frame
//     tx            serial line (registered, idle high)
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | line high, waiting for tx_start
//   ST_START  | start bit (low) for OSR ticks
//   ST_DATA   | data bit shift[0] for OSR ticks, DBIT times
//   ST_PARITY | parity bit for OSR ticks (PARITY != PAR_NONE only)
//   ST_STOP   | line high for SB_TICK ticks, then done pulse
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic            s_tick,
  input  logic [DBIT-1:0] din,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = $clog2(DBIT);
  localparam int SW = $clog2((SB_TICK > OSR) ? SB_TICK : OSR);

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OSR - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d = din;
          // parity is fixed from the captured word; the shift register
          // is consumed bit by bit and cannot be used for it later
          par_d   = parity_line(^din, PARITY);
          s_d     = '0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // Line level follows the next state so tx changes on the same edge as
  // the state register; in DATA it uses the post-shift word.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Directed + randomized bench for uart_tx. Three instances share the
//   stimulus: default (no parity), even parity and odd parity. Expected line
//   levels come from a frame model indexed by the number of s_tick pulses
//   seen since the request was accepted.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;

  logic tx_n, done_n;
  logic tx_e, done_e;
  logic tx_o, done_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) dut_none (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_n), .tx(tx_n)
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) dut_even (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_e), .tx(tx_e)
  );

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) dut_odd (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick),
    .din(din), .tx_done_tick(done_o), .tx(tx_o)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    case (w)
      0:       return tx_n;
      1:       return tx_e;
      default: return tx_o;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0:       return done_n;
      1:       return done_e;
      default: return done_o;
    endcase
  endfunction

  // Reference frame: slot 0 start, slots 1..8 data LSB first, slot 9 parity
  // when enabled, then stop. Each slot is 16 ticks.
  function automatic logic exp_bit(input logic [7:0] d, input int par_mode, input int k);
    int slot;
    int ones;
    slot = k / 16;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (slot == 9 && par_mode != 0) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      if (par_mode == 1) return logic'(ones % 2);
      return logic'(1 - (ones % 2));
    end
    return 1'b1;
  endfunction

  // mode: 0 = s_tick always high, 1 = one tick every 4 clks, 2 = random.
  // hold keeps tx_start high so the next frame is accepted in the done cycle.
  // abort_k >= 0 asserts reset once that many ticks have elapsed.
  task automatic send_frame(input int w, input logic [7:0] data, input int mode,
                            input bit hold, input int abort_k);
    int  k = 0;
    int  c = 0;
    int  total;
    logic st;
    total = 16 * (10 + ((w != 0) ? 1 : 0));
    din      = data;
    tx_start = 1'b1;
    s_tick   = logic'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("start_edge_tx", get_tx(w), 1'b0);
    check("start_edge_done", get_done(w), 1'b0);
    while (k < total) begin
      case (mode)
        0:       st = 1'b1;
        1:       st = ((c % 4) == 3);
        default: st = ($urandom_range(0, 2) != 0);
      endcase
      c++;
      s_tick = st;
      din    = 8'($urandom);
      if (!hold) tx_start = logic'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (st) k++;
      if (k == total) begin
        check("gap_tx", get_tx(w), 1'b1);
        check("done_pulse", get_done(w), 1'b1);
      end else begin
        check("frame_tx", get_tx(w), exp_bit(data, w, k));
        check("frame_done", get_done(w), 1'b0);
      end
      if (abort_k >= 0 && k == abort_k) begin
        #2 reset = 1'b0;
        #1;
        check("abort_tx_async", get_tx(w), 1'b1);
        check("abort_done", get_done(w), 1'b0);
        repeat (4) begin
          @(posedge clk); #1;
          check("abort_hold_tx", get_tx(w), 1'b1);
          check("abort_hold_done", get_done(w), 1'b0);
        end
        reset    = 1'b1;
        tx_start = 1'b0;
        return;
      end
      if (c > 20000) begin
        vectors++;
        miscompares++;
        $error("FAIL frame_timeout: observed ticks %0d expected %0d", k, total);
        return;
      end
    end
    if (!hold) begin
      tx_start = 1'b0;
      s_tick   = 1'b1;
      @(posedge clk); #1;
      check("after_idle_tx", get_tx(w), 1'b1);
      check("after_idle_done", get_done(w), 1'b0);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset    = 1'b0;
    tx_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    tx_start = 1'b1;
    s_tick   = 1'b1;
    din      = 8'hBE;

    repeat (5) begin
      @(posedge clk); #1;
      check("rst_tx_none", tx_n, 1'b1);
      check("rst_done_none", done_n, 1'b0);
      check("rst_tx_even", tx_e, 1'b1);
      check("rst_tx_odd", tx_o, 1'b1);
    end
    reset    = 1'b1;
    tx_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_tx", tx_n, 1'b1);
      check("idle_done", done_n, 1'b0);
    end

    send_frame(0, 8'hBE, 0, 1'b0, -1);

    send_frame(0, 8'hBE, 0, 1'b1, -1);
    send_frame(0, 8'hBE, 0, 1'b1, -1);
    send_frame(0, 8'hBE, 0, 1'b0, -1);

    send_frame(0, 8'h55, 1, 1'b0, -1);

    for (int i = 0; i < 4; i++) send_frame(0, 8'($urandom), 2, 1'b0, -1);

    pulse_reset();
    send_frame(1, 8'h07, 0, 1'b0, -1);
    pulse_reset();
    send_frame(2, 8'h07, 0, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      pulse_reset();
      send_frame(1 + (i % 2), 8'($urandom), 2, 1'b0, -1);
    end

    pulse_reset();
    send_frame(0, 8'h00, 0, 1'b0, 40);
    send_frame(0, 8'($urandom), 0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
